// File: rtl/pkt_merge_n.sv
// pkt_merge_n: N-input packet merger, per-port FIFOs drained by a packet-atomic round-robin arbiter.
// Define PKT_MERGE_STATS_EN to add per-port output packet counters on pkt_count.
module pkt_merge_n #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_W     = 153,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS-1:0]          in_valid,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready
`ifdef PKT_MERGE_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0]       pkt_count
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(NUM_PORTS);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nx;
   logic [GW-1:0] last_grant, last_grant_nx, lock_port, lock_port_nx, sel, idx;
   logic sel_ok, load;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] mem [NUM_PORTS][FIFO_DEPTH];
   logic [PW-1:0] wr_ptr [NUM_PORTS];
   logic [PW-1:0] rd_ptr [NUM_PORTS];
   logic [PW:0] cnt [NUM_PORTS];
   logic [NUM_PORTS-1:0] empty, full, push, pop;
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         empty[i] = cnt[i] == '0;
         full[i]  = cnt[i] == (PW+1)'(FIFO_DEPTH);
      end
   end
   assign in_ready = ~full & {NUM_PORTS{~reset}};
   assign push     = in_valid & in_ready;
   // A locked packet owns the output even while its FIFO is empty, so it bubbles rather than yields.
   always_comb begin
      sel    = lock_port;
      sel_ok = 1'b0;
      idx    = '0;
      if (state == LOCKED)
         sel_ok = !empty[lock_port];
      else
         for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_PORTS);
            if (!sel_ok && !empty[idx]) begin
               sel    = idx;
               sel_ok = 1'b1;
            end
         end
      head = mem[sel][rd_ptr[sel]];
      load = (!out_valid || out_ready) && sel_ok;
      for (int i = 0; i < NUM_PORTS; i++)
         pop[i] = load && sel == GW'(i);
      state_nx      = state;
      last_grant_nx = last_grant;
      lock_port_nx  = lock_port;
      if (load) begin
         state_nx      = head[DATA_W-1] ? IDLE : LOCKED;
         lock_port_nx  = sel;
         last_grant_nx = head[DATA_W-1] ? sel : last_grant;
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (reset) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end else begin
            if (push[i]) begin
               mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
               wr_ptr[i]         <= wr_ptr[i] + PW'(1);
            end
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PW'(1);
            cnt[i] <= cnt[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GW'(NUM_PORTS - 1);
         lock_port  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         lock_port  <= lock_port_nx;
         if (!out_valid || out_ready) begin
            out_valid <= sel_ok;
            if (sel_ok)
               out_data <= head;
         end
      end
   end
`ifdef PKT_MERGE_STATS_EN
   logic [GW-1:0] out_port;
   always_ff @(posedge clk) begin
      if (reset)
         out_port <= '0;
      else if (load)
         out_port <= sel;
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (reset)
            pkt_count[i*16 +: 16] <= '0;
         else if (out_valid && out_ready && out_data[DATA_W-1] && out_port == GW'(i))
            pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pkt_merge_n.sv
// tb_pkt_merge_n: vector table plus directed sequences for pkt_merge_n (4 ports, 16-bit words, depth 4).
module tb_pkt_merge_n;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [63:0] in_data = '0;
   logic [3:0] in_valid = '0;
   logic [3:0] in_ready;
   logic [15:0] out_data;
   logic out_valid;
   logic out_ready = 1'b1;
`ifdef PKT_MERGE_STATS_EN
   logic [63:0] pkt_count;
`endif
   int ncmp = 0;
   int nfail = 0;
   int ncyc = 0;
   logic [15:0] mon [$];
   int mcyc [$];

   pkt_merge_n #(.NUM_PORTS(4), .DATA_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PKT_MERGE_STATS_EN
      , .pkt_count(pkt_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;
   always @(negedge clk)
      if (!reset && out_valid && out_ready) begin
         mon.push_back(out_data);
         mcyc.push_back(ncyc);
      end

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic [63:0] dat;
      logic        ovld;
      logic [15:0] odat;
      logic [3:0]  irdy;
   } vec_t;
   vec_t tv [$];

   function automatic void add(input logic r, input logic [3:0] v, input logic [63:0] d,
                               input logic ev, input logic [15:0] ed, input logic [3:0] er);
      vec_t t;
      t.rst = r; t.vld = v; t.dat = d; t.ovld = ev; t.odat = ed; t.irdy = er;
      tv.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] v, input logic [63:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) cyc(4'h0, 64'h0);
      reset = 1'b0;
      mon.delete();
      mcyc.delete();
   endtask

   function automatic logic [15:0] got(input int i);
      return (i < mon.size()) ? mon[i] : 16'hxxxx;
   endfunction

   initial begin
      int acc;
      logic r;
      logic [15:0] exp_bp [5];
      // reset and idle
      repeat (3) add(1'b1, 4'h0, 64'h0, 1'b0, 16'h0, 4'h0);
      add(1'b0, 4'h0, 64'h0, 1'b0, 16'h0, 4'hF);
      // 3-word packet on port 0, then a single-word packet on port 1 proves return to IDLE
      add(1'b0, 4'h1, 64'h0001, 1'b0, 16'h0, 4'hF);
      add(1'b0, 4'h1, 64'h0002, 1'b1, 16'h0001, 4'hF);
      add(1'b0, 4'h1, 64'h8003, 1'b1, 16'h0002, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8003, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b0, 16'h0, 4'hF);
      add(1'b0, 4'h2, 64'h0000_0000_8101_0000, 1'b0, 16'h0, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8101, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b0, 16'h0, 4'hF);
      // contention: every port starts a 2-word packet in the same cycle after reset
      repeat (2) add(1'b1, 4'h0, 64'h0, 1'b0, 16'h0, 4'h0);
      add(1'b0, 4'hF, 64'h0301_0201_0101_0001, 1'b0, 16'h0, 4'hF);
      add(1'b0, 4'hF, 64'h8302_8202_8102_8002, 1'b1, 16'h0001, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8002, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h0101, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8102, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h0201, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8202, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h0301, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b1, 16'h8302, 4'hF);
      add(1'b0, 4'h0, 64'h0, 1'b0, 16'h0, 4'hF);
      foreach (tv[i]) begin
         reset = tv[i].rst;
         cyc(tv[i].vld, tv[i].dat);
         chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tv[i].irdy));
         chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tv[i].ovld));
         if (tv[i].ovld || tv[i].rst)
            chk($sformatf("row%0d out_data", i), 64'(out_data), 64'(tv[i].odat));
      end

      // lock with bubble: port 1 stalls mid-packet while port 0 waits with a full packet
      do_reset();
      cyc(4'h2, 64'h0000_0000_0101_0000);
      cyc(4'h1, 64'h0001);
      cyc(4'h1, 64'h8002);
      repeat (3) cyc(4'h0, 64'h0);
      cyc(4'h2, 64'h0000_0000_8102_0000);
      repeat (6) cyc(4'h0, 64'h0);
      chk("bubble count", 64'(mon.size()), 64'd4);
      chk("bubble w0", 64'(got(0)), 64'h0101);
      chk("bubble w1", 64'(got(1)), 64'h8102);
      chk("bubble w2", 64'(got(2)), 64'h0001);
      chk("bubble w3", 64'(got(3)), 64'h8002);
      if (mcyc.size() >= 2)
         chk("bubble gap>=6", 64'(mcyc[1] - mcyc[0] >= 6), 64'd1);
      else
         chk("bubble gap samples", 64'(mcyc.size()), 64'd2);

      // backpressure: 4 FIFO slots + output register absorb 5 words
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         r = in_ready[0];
         cyc({3'b000, r}, 64'(16'h0010 + acc[15:0]));
         if (r) acc++;
      end
      chk("bp accepts", 64'(acc), 64'd5);
      chk("bp in_ready", 64'(in_ready), 64'hE);
      chk("bp out_valid held", 64'(out_valid), 64'd1);
      chk("bp out_data held", 64'(out_data), 64'h0010);
      out_ready = 1'b1;
      repeat (8) cyc(4'h0, 64'h0);
      exp_bp = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
      chk("bp drain count", 64'(mon.size()), 64'd5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("bp drain w%0d", k), 64'(got(k)), 64'(exp_bp[k]));
      chk("bp in_ready after", 64'(in_ready), 64'hF);

`ifdef PKT_MERGE_STATS_EN
      do_reset();
      cyc(4'h3, 64'h0000_0000_8101_8001);
      cyc(4'h3, 64'h0000_0000_8102_8002);
      cyc(4'h2, 64'h0000_0000_8103_0000);
      repeat (8) cyc(4'h0, 64'h0);
      chk("stats p1/p0", 64'(pkt_count[31:0]), 64'h0003_0002);
      chk("stats p3/p2", 64'(pkt_count[63:32]), 64'h0);
      reset = 1'b1;
      cyc(4'h0, 64'h0);
      reset = 1'b0;
      chk("stats reset", pkt_count, 64'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
